// File: rtl/bcd_addsub_serial.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first,
// with a single shared 4-bit digit adder and ten's-complement subtract.
module bcd_addsub_serial #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op_sub,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                carry,
  output logic                err
);

  localparam int unsigned     W    = 4 * DIGITS;
  localparam int unsigned     CW   = $clog2(DIGITS) + 1;
  localparam logic [CW-1:0]   LAST = CW'(DIGITS - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic            sub_q, sub_d, c_q, c_d;
  logic            carry_q, carry_d, err_q, err_d, done_q, done_d;
  logic [3:0]      a_dig, b_dig, bd, dig;
  logic [4:0]      t;
  logic            in_bad;

  always_comb begin
    in_bad = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) in_bad = 1'b1;
    end
  end

  // Shared digit slice: counter selects the operand digits for this cycle.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (cnt_q == CW'(i)) begin
        a_dig = a_q[4*i +: 4];
        b_dig = b_q[4*i +: 4];
      end
    end
    bd  = sub_q ? (4'd9 - b_dig) : b_dig;
    t   = 5'(a_dig) + 5'(bd) + 5'(c_q);
    dig = (t > 5'd9) ? 4'(t + 5'd6) : t[3:0];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    c_d     = c_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (in_bad) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            sum_d   = '0;
            carry_d = 1'b0;
          end else begin
            a_d     = a;
            b_d     = b;
            sub_d   = op_sub;
            c_d     = op_sub;
            cnt_d   = '0;
            state_d = CALC;
          end
        end
      end
      CALC: begin
        c_d = (t > 5'd9);
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (cnt_q == CW'(i)) res_d[4*i +: 4] = dig;
        end
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
          err_d   = 1'b0;
          sum_d   = res_d;
          carry_d = sub_q ? ~c_d : c_d;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q == CALC);
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Bench for bcd_addsub_serial at DIGITS=1/4/8 against a decimal-arithmetic model.
module tb_bcd_addsub_serial;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st1 = 1'b0, st4 = 1'b0, st8 = 1'b0;
  logic        sub_in = 1'b0;
  logic [31:0] a_in = '0, b_in = '0;

  logic        busy1, done1, carry1, err1;
  logic [3:0]  sum1;
  logic        busy4, done4, carry4, err4;
  logic [15:0] sum4;
  logic        busy8, done8, carry8, err8;
  logic [31:0] sum8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bcd_addsub_serial #(.DIGITS(1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .op_sub(sub_in), .a(a_in[3:0]), .b(b_in[3:0]),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1), .err(err1));
  bcd_addsub_serial #(.DIGITS(4)) u4 (
    .clk(clk), .rst(rst), .start(st4), .op_sub(sub_in), .a(a_in[15:0]), .b(b_in[15:0]),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4), .err(err4));
  bcd_addsub_serial #(.DIGITS(8)) u8 (
    .clk(clk), .rst(rst), .start(st8), .op_sub(sub_in), .a(a_in), .b(b_in),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8), .err(err8));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] o_sum(input int d);
    case (d)
      1:       return {28'b0, sum1};
      4:       return {16'b0, sum4};
      default: return sum8;
    endcase
  endfunction
  function automatic logic o_busy(input int d);
    return (d == 1) ? busy1 : (d == 4) ? busy4 : busy8;
  endfunction
  function automatic logic o_done(input int d);
    return (d == 1) ? done1 : (d == 4) ? done4 : done8;
  endfunction
  function automatic logic o_carry(input int d);
    return (d == 1) ? carry1 : (d == 4) ? carry4 : carry8;
  endfunction
  function automatic logic o_err(input int d);
    return (d == 1) ? err1 : (d == 4) ? err4 : err8;
  endfunction

  task automatic set_start(input int d, input logic v);
    case (d)
      1:       st1 = v;
      4:       st4 = v;
      default: st8 = v;
    endcase
  endtask

  function automatic logic [3:0] nib(input logic [31:0] x, input int i);
    return 4'(x >> (4 * i));
  endfunction

  function automatic bit has_bad(input int d, input logic [31:0] av, input logic [31:0] bv);
    for (int i = 0; i < d; i++)
      if (nib(av, i) > 4'd9 || nib(bv, i) > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  function automatic longint to_int(input int d, input logic [31:0] x);
    longint v = 0;
    for (int i = d - 1; i >= 0; i--) v = v * 10 + longint'(nib(x, i));
    return v;
  endfunction

  // Reference: plain decimal arithmetic modulo 10^d.
  task automatic model(input int d, input logic sub, input logic [31:0] av, input logic [31:0] bv,
                       output logic [31:0] es, output logic ec);
    longint p = 1, va, vb, r;
    for (int i = 0; i < d; i++) p = p * 10;
    va = to_int(d, av);
    vb = to_int(d, bv);
    if (!sub) begin
      r  = va + vb;
      ec = (r >= p);
      r  = r % p;
    end else if (va >= vb) begin
      r  = va - vb;
      ec = 1'b0;
    end else begin
      r  = p - (vb - va);
      ec = 1'b1;
    end
    es = '0;
    for (int i = 0; i < d; i++) begin
      es = es | (32'(r % 10) << (4 * i));
      r  = r / 10;
    end
  endtask

  function automatic logic [31:0] rand_bcd(input int d, input bit allow_bad);
    logic [31:0] r = '0;
    logic [3:0]  n;
    for (int i = 0; i < d; i++) begin
      n = 4'($urandom_range(9, 0));
      if (allow_bad && $urandom_range(24, 0) == 0) n = 4'($urandom_range(15, 10));
      r = r | (32'(n) << (4 * i));
    end
    return r;
  endfunction

  task automatic do_op(input int d, input logic sub, input logic [31:0] av, input logic [31:0] bv,
                       input bit repulse, input bit hold, input string tag);
    logic [31:0] es, sum0;
    logic        ec;
    int          busyc = 0, early = 0, moved = 0;
    model(d, sub, av, bv, es, ec);
    @(negedge clk);
    a_in = av; b_in = bv; sub_in = sub;
    set_start(d, 1'b1);
    @(posedge clk); #1;
    if (!hold) set_start(d, 1'b0);
    if (has_bad(d, av, bv)) begin
      check({tag, ".bad_done"},  32'(o_done(d)),  32'd1);
      check({tag, ".bad_err"},   32'(o_err(d)),   32'd1);
      check({tag, ".bad_sum"},   o_sum(d),        32'd0);
      check({tag, ".bad_carry"}, 32'(o_carry(d)), 32'd0);
      check({tag, ".bad_busy"},  32'(o_busy(d)),  32'd0);
      @(posedge clk); #1;
      check({tag, ".bad_pulse"}, 32'({o_done(d), o_busy(d)}), 32'd0);
      return;
    end
    sum0 = o_sum(d);
    if (o_busy(d)) busyc++;
    if (o_done(d)) early++;
    for (int k = 1; k <= d; k++) begin
      @(posedge clk); #1;
      if (repulse && k == 2) set_start(d, 1'b0);
      if (k < d) begin
        if (o_busy(d)) busyc++;
        if (o_done(d)) early++;
        if (o_sum(d) !== sum0) moved++;
        if (repulse && k == 1) begin
          a_in = $urandom; b_in = $urandom; sub_in = ~sub;
          set_start(d, 1'b1);
        end
      end
    end
    check({tag, ".done"},  32'(o_done(d)),  32'd1);
    check({tag, ".busy"},  32'(o_busy(d)),  32'd0);
    check({tag, ".sum"},   o_sum(d),        es);
    check({tag, ".carry"}, 32'(o_carry(d)), 32'(ec));
    check({tag, ".err"},   32'(o_err(d)),   32'd0);
    check({tag, ".busy_cycles"}, 32'(busyc), 32'(d));
    check({tag, ".early_done"},  32'(early + moved), 32'd0);
  endtask

  task automatic tp(input string tag, input logic sub, input logic [31:0] av, input logic [31:0] bv,
                    input logic [31:0] esum, input logic ec);
    do_op(4, sub, av, bv, 1'b0, 1'b0, tag);
    check({tag, ".tp_sum"},   o_sum(4),        esum);
    check({tag, ".tp_carry"}, 32'(o_carry(4)), 32'(ec));
  endtask

  initial begin
    int held_done;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy",  32'(busy4),  32'd0);
    check("rst.done",  32'(done4),  32'd0);
    check("rst.sum",   32'(sum4),   32'd0);
    check("rst.carry", 32'(carry4), 32'd0);
    check("rst.err",   32'(err4),   32'd0);
    check("rst.sum8",  sum8,        32'd0);
    @(negedge clk);
    rst = 1'b0;

    tp("add0999", 1'b0, 32'h0999, 32'h0001, 32'h1000, 1'b0);
    tp("add9999", 1'b0, 32'h9999, 32'h0001, 32'h0000, 1'b1);
    tp("add4567", 1'b0, 32'h4567, 32'h5678, 32'h0245, 1'b1);
    tp("sub0500", 1'b1, 32'h0500, 32'h0123, 32'h0377, 1'b0);
    tp("sub0123", 1'b1, 32'h0123, 32'h0500, 32'h9623, 1'b1);
    tp("sub2024", 1'b1, 32'h2024, 32'h2024, 32'h0000, 1'b0);

    do_op(4, 1'b0, 32'h0A00, 32'h0001, 1'b0, 1'b0, "invalid");
    tp("after_inv", 1'b0, 32'h0321, 32'h0456, 32'h0777, 1'b0);

    do_op(4, 1'b0, 32'h3141, 32'h2718, 1'b1, 1'b0, "repulse");
    do_op(4, 1'b1, 32'h5000, 32'h0001, 1'b0, 1'b1, "hold1");
    do_op(4, 1'b0, 32'h0042, 32'h0058, 1'b0, 1'b0, "hold2");

    tp("pre_rst", 1'b0, 32'h1111, 32'h2222, 32'h3333, 1'b0);
    @(negedge clk);
    a_in = 32'h0999; b_in = 32'h0001; sub_in = 1'b0; st4 = 1'b1;
    @(posedge clk); #1; st4 = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst.outs", {busy4, done4, carry4, err4, 12'b0, sum4}, 32'd0);
    held_done = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done4 || busy4) held_done++;
    end
    check("midrst.no_done", 32'(held_done), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tp("post_rst", 1'b0, 32'h1234, 32'h4321, 32'h5555, 1'b0);

    do_op(1, 1'b0, 32'h9, 32'h1, 1'b0, 1'b0, "d1_add");
    check("d1.tp_sum",   o_sum(1),        32'h0);
    check("d1.tp_carry", 32'(o_carry(1)), 32'd1);
    do_op(8, 1'b0, 32'h0999, 32'h0001, 1'b0, 1'b0, "d8_add");
    check("d8.tp_sum",   o_sum(8),        32'h1000);
    do_op(8, 1'b1, 32'h00000001, 32'h99999999, 1'b0, 1'b0, "d8_sub");

    for (int n = 0; n < 40; n++) begin
      do_op(1, 1'($urandom_range(1, 0)), rand_bcd(1, 1'b1), rand_bcd(1, 1'b1), 1'b0, 1'b0, "rnd1");
      do_op(4, 1'($urandom_range(1, 0)), rand_bcd(4, 1'b1), rand_bcd(4, 1'b1), 1'b0, 1'b0, "rnd4");
      do_op(8, 1'($urandom_range(1, 0)), rand_bcd(8, 1'b1), rand_bcd(8, 1'b1), 1'b0, 1'b0, "rnd8");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
